cp0_irq_ctrl: RTL and testbench
===============================

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (legal range 1..8).
REQ-002 SHALL have parameter EBASE_RST, default 32'h0000_0080, reset value of EBASE.
REQ-003 SHALL have ports (clock and reset first): clk_cpu input 1, rising-edge clock; rst input 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports irq_i input NUM_IRQ, level interrupt requests; exc_valid input 1, synchronous exception; exc_code input 5, exception code; exc_pc input 32, faulting PC; int_pc input 32, resume PC for interrupts.
REQ-005 SHALL have ports eret input 1, return from handler; mtc_en input 1, mtc_addr input 5, mtc_data input 32, CPR write; mfc_addr input 5, CPR read address; mfc_data output 32, CPR read data.
REQ-006 SHALL have ports trap_valid output 1, trap pulse; trap_vector output 32, handler address; eret_pc output 32, EPC on eret; status_data, cause_data, epc_data output 32; in_handler output 1, mirrors Status.EXL.

Function
REQ-007 SHALL hold Status (CPR12: bit0 IE, bit1 EXL, bits 8+k IM[k]), Cause (CPR13: bits 6:2 ExcCode, bits 8+k IP[k]), EPC (CPR14) and EBASE (CPR15); all other CPR addresses read 0 and ignore writes.
REQ-008 SHALL read mfc_data combinationally from the selected register; status/cause/epc_data SHALL be continuous copies.
REQ-009 SHALL register irq_i each cycle and set IP[k] on the cycle after a 0->1 transition of irq_i[k]; an IP bit SHALL stay set until cleared.
REQ-010 SHALL treat an mtc write to Cause as write-1-to-clear of IP bits; ExcCode is read-only to software; a rising edge in the same cycle SHALL win (IP stays 1).
REQ-011 SHALL have a two-state FSM: RUN (EXL=0) and HANDLER (EXL=1).
REQ-012 In any state, exc_valid=1 SHALL take an exception at the clock edge: ExcCode<=exc_code, EXL<=1; EPC<=exc_pc only if EXL was 0.
REQ-013 In RUN with IE=1, no exc_valid and (IP&IM)!=0, SHALL take the interrupt at the clock edge: ExcCode<=0, EPC<=int_pc, EXL<=1.
REQ-014 Among pending enabled interrupts, SHALL select the lowest index k.
REQ-015 SHALL pulse trap_valid high for exactly one cycle, the cycle after the trap-taking edge, with trap_vector valid the same cycle; trap_valid SHALL be 0 otherwise.
REQ-016 eret=1 in HANDLER SHALL clear EXL at the edge and present eret_pc=EPC combinationally in the eret cycle; eret in RUN SHALL have no effect.
REQ-017 exc_valid and eret in the same cycle: exception wins, EXL stays 1, eret is ignored.
REQ-018 mtc to Status/EPC/EBASE SHALL update at the edge; a same-cycle hardware update of EXL or EPC SHALL override the software value for those fields.
REQ-019 EBASE writes SHALL force bits 4:0 to 0.

Reset
REQ-020 rst SHALL immediately clear Status, Cause, EPC, the irq_i sample register and trap_valid; set EBASE to EBASE_RST; set FSM to RUN.
REQ-021 rst asserted mid-trap SHALL suppress any pending trap_valid pulse; no IP bit SHALL be set by irq_i already high at reset release until it falls and rises again.

Configuration
REQ-022 With macro CP0_VECTORED_IRQ_EN defined, interrupt k SHALL vector to EBASE + 32*(k+1) and exceptions to EBASE.
REQ-023 Without CP0_VECTORED_IRQ_EN, all traps SHALL vector to EBASE; no other behaviour SHALL change.

Verification
REQ-024 Reset, then read CPR12/13/14/15 via mfc -> 0, 0, 0, 32'h80; trap_valid 0.
REQ-025 Status=32'h0000_0301, irq_i[1] 0->1, int_pc=32'h400 -> IP1 set, trap next edge, trap_valid one cycle, EPC=32'h400, EXL=1, trap_vector 32'hC0 (vectored) or 32'h80.
REQ-026 irq_i[0] and irq_i[2] rise together, IM=4'b0101, IE=1 -> IRQ0 taken; IRQ2 stays pending and is taken after eret clears EXL.
REQ-027 In HANDLER with EPC=32'h400, exc_valid with exc_code=5'd12 and exc_pc=32'h800 -> ExcCode=12, EPC stays 32'h400, trap_valid pulses.
REQ-028 exc_valid (code 5'd1) and eret in the same cycle in HANDLER -> EXL stays 1, ExcCode=1, no return.
REQ-029 mtc Cause with 32'h0000_0200 while IP1=1 -> IP1=0; repeat while irq_i[1] rises the same cycle -> IP1 stays 1.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// CP0-style exception/interrupt controller: Status, Cause, EPC and EBASE registers,
// IRQ edge capture and a RUN/HANDLER trap sequencer. Define CP0_VECTORED_IRQ_EN for per-IRQ vectors.
module cp0_irq_ctrl #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] EBASE_RST = 32'h0000_0080
) (
    input  logic               clk_cpu,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic [31:0]        int_pc,
    input  logic               eret,
    input  logic               mtc_en,
    input  logic [4:0]         mtc_addr,
    input  logic [31:0]        mtc_data,
    input  logic [4:0]         mfc_addr,
    output logic [31:0]        mfc_data,
    output logic               trap_valid,
    output logic [31:0]        trap_vector,
    output logic [31:0]        eret_pc,
    output logic [31:0]        status_data,
    output logic [31:0]        cause_data,
    output logic [31:0]        epc_data,
    output logic               in_handler
);
    localparam logic [4:0] CPR_STATUS = 5'd12;
    localparam logic [4:0] CPR_CAUSE  = 5'd13;
    localparam logic [4:0] CPR_EPC    = 5'd14;
    localparam logic [4:0] CPR_EBASE  = 5'd15;

    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t             state;
    logic               status_ie;
    logic [NUM_IRQ-1:0] status_im;
    logic [NUM_IRQ-1:0] cause_ip;
    logic [4:0]         cause_exc;
    logic [31:0]        epc;
    logic [31:0]        ebase;
    logic [NUM_IRQ-1:0] irq_q;
    logic               irq_armed;

    logic               wr_status, wr_cause, wr_epc, wr_ebase;
    logic               exl, take_exc, take_int;
    logic [NUM_IRQ-1:0] irq_rise, irq_pend, ip_clr;
    logic [31:0]        vector_next;

    assign wr_status = mtc_en && (mtc_addr == CPR_STATUS);
    assign wr_cause  = mtc_en && (mtc_addr == CPR_CAUSE);
    assign wr_epc    = mtc_en && (mtc_addr == CPR_EPC);
    assign wr_ebase  = mtc_en && (mtc_addr == CPR_EBASE);

    // irq_armed blocks the first post-reset sample so lines already high never count as a rise.
    assign exl      = (state == HANDLER);
    assign irq_rise = irq_i & ~irq_q & {NUM_IRQ{irq_armed}};
    assign irq_pend = cause_ip & status_im;
    assign ip_clr   = wr_cause ? mtc_data[8 +: NUM_IRQ] : '0;
    assign take_exc = exc_valid;
    assign take_int = !exl && status_ie && !exc_valid && (|irq_pend);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        status_data                = '0;
        status_data[0]             = status_ie;
        status_data[1]             = exl;
        status_data[8 +: NUM_IRQ]  = status_im;
        cause_data                 = '0;
        cause_data[6:2]            = cause_exc;
        cause_data[8 +: NUM_IRQ]   = cause_ip;
    end

    assign epc_data   = epc;
    assign eret_pc    = epc;
    assign in_handler = exl;

    always_comb begin
        case (mfc_addr)
            CPR_STATUS: mfc_data = status_data;
            CPR_CAUSE:  mfc_data = cause_data;
            CPR_EPC:    mfc_data = epc;
            CPR_EBASE:  mfc_data = ebase;
            default:    mfc_data = '0;
        endcase
    end

`ifdef CP0_VECTORED_IRQ_EN
    logic [2:0] irq_idx;

    // Scan from the top down so the last hit, the lowest pending index, wins.
    always_comb begin
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_pend[k]) irq_idx = 3'(k);
        end
    end

    assign vector_next = take_int ? ebase + ((32'(irq_idx) + 32'd1) << 5) : ebase;
`else
    assign vector_next = ebase;
`endif

    // NOTE: asynchronous reset sits in the sensitivity list; all sequential state uses <= only.
    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            status_ie <= 1'b0;
            status_im <= '0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
            ebase     <= EBASE_RST;
            irq_q     <= '0;
            irq_armed <= 1'b0;
        end else begin
            irq_q     <= irq_i;
            irq_armed <= 1'b1;
            if (wr_status) begin
                status_ie <= mtc_data[0];
                status_im <= mtc_data[8 +: NUM_IRQ];
            end
            // Write-1-to-clear; a rising edge in the same cycle keeps the bit set.
            cause_ip <= (cause_ip & ~ip_clr) | irq_rise;
            if (take_exc)      cause_exc <= exc_code;
            else if (take_int) cause_exc <= '0;
            // A nested exception keeps the original return address.
            if (take_exc && !exl) epc <= exc_pc;
            else if (take_int)    epc <= int_pc;
            else if (wr_epc)      epc <= mtc_data;
            if (wr_ebase) ebase <= {mtc_data[31:5], 5'b0};
        end
    end

    // State is Status.EXL: hardware trap/eret events override a same-cycle software write.
    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            trap_valid  <= 1'b0;
            trap_vector <= '0;
        end else begin
            trap_valid  <= take_exc || take_int;
            trap_vector <= vector_next;
            case (state)
                RUN: begin
                    if (take_exc || take_int)      state <= HANDLER;
                    else if (wr_status && mtc_data[1]) state <= HANDLER;
                end
                HANDLER: begin
                    if (exc_valid)      state <= HANDLER;
                    else if (eret)      state <= RUN;
                    else if (wr_status) state <= mtc_data[1] ? HANDLER : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: directed scenarios plus random traffic against a
// rule-level reference model; a separate monitor compares on every falling clock edge.
`timescale 1ns/1ps
module tb_cp0_irq_ctrl;
    localparam int N = 4;
`ifdef CP0_VECTORED_IRQ_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif
    localparam logic [31:0] EXP_VEC_IRQ0 = VECTORED ? 32'hA0 : 32'h80;
    localparam logic [31:0] EXP_VEC_IRQ1 = VECTORED ? 32'hC0 : 32'h80;
    localparam logic [31:0] EXP_VEC_IRQ2 = VECTORED ? 32'hE0 : 32'h80;

    logic          clk_cpu = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq_i = '0;
    logic          exc_valid = 1'b0;
    logic [4:0]    exc_code = '0;
    logic [31:0]   exc_pc = '0;
    logic [31:0]   int_pc = '0;
    logic          eret = 1'b0;
    logic          mtc_en = 1'b0;
    logic [4:0]    mtc_addr = '0;
    logic [31:0]   mtc_data = '0;
    logic [4:0]    mfc_addr = '0;
    logic [31:0]   mfc_data, trap_vector, eret_pc, status_data, cause_data, epc_data;
    logic          trap_valid, in_handler;

    cp0_irq_ctrl #(.NUM_IRQ(N), .EBASE_RST(32'h0000_0080)) dut (
        .clk_cpu(clk_cpu), .rst(rst), .irq_i(irq_i),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .int_pc(int_pc),
        .eret(eret), .mtc_en(mtc_en), .mtc_addr(mtc_addr), .mtc_data(mtc_data),
        .mfc_addr(mfc_addr), .mfc_data(mfc_data),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .eret_pc(eret_pc),
        .status_data(status_data), .cause_data(cause_data), .epc_data(epc_data),
        .in_handler(in_handler)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents as plain variables.
    bit          m_ie, m_exl, m_trap, m_prev_ok;
    bit [N-1:0]  m_im, m_ip, m_prev;
    int unsigned m_exc;
    logic [31:0] m_epc, m_ebase;

    typedef struct {
        logic [31:0] status, cause, epc, mfc, eret_pc;
        logic        in_h, trap, eret_chk;
    } snap_t;
    snap_t       snap_q[$];
    logic [31:0] trap_q[$];

    function automatic logic [31:0] m_status();
        return 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_exc) << 2) | (32'(m_ip) << 8);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return m_ebase;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_trap = 0; m_prev_ok = 0;
        m_im = '0; m_ip = '0; m_prev = '0;
        m_exc = 0; m_epc = '0; m_ebase = 32'h80;
        trap_q.delete();
    endtask

    // One clock: record expectations for the current cycle, predict the edge, advance.
    task automatic tick();
        snap_t       s;
        bit [N-1:0]  rise, pend, ip_n, im_n, irq_s;
        bit          ie_n, exl_n, t_exc, t_int, live;
        int          k_sel;
        int unsigned exc_n;
        logic [31:0] epc_n, ebase_n;
        if (rst) model_reset();
        s.status = m_status(); s.cause = m_cause(); s.epc = m_epc;
        s.mfc = m_read(mfc_addr); s.in_h = m_exl; s.trap = m_trap;
        s.eret_chk = eret; s.eret_pc = m_epc;
        snap_q.push_back(s);
        live = !rst;
        irq_s = irq_i;
        rise = m_prev_ok ? (irq_s & ~m_prev) : '0;
        pend = m_ip & m_im;
        t_exc = live && exc_valid;
        t_int = live && !m_exl && m_ie && !exc_valid && (pend != 0);
        k_sel = -1;
        for (int k = 0; k < N; k++) if (pend[k] && k_sel < 0) k_sel = k;
        ip_n = m_ip;
        if (mtc_en && mtc_addr == 5'd13) ip_n = ip_n & ~mtc_data[8 +: N];
        ip_n = ip_n | rise;
        ie_n = m_ie; im_n = m_im; exl_n = m_exl;
        if (mtc_en && mtc_addr == 5'd12) begin
            ie_n = mtc_data[0]; exl_n = mtc_data[1]; im_n = mtc_data[8 +: N];
        end
        if (t_exc || t_int) exl_n = 1;
        else if (m_exl && eret) exl_n = 0;
        exc_n = t_exc ? 32'(exc_code) : (t_int ? 0 : m_exc);
        epc_n = m_epc;
        if (mtc_en && mtc_addr == 5'd14) epc_n = mtc_data;
        if (t_int) epc_n = int_pc;
        if (t_exc && !m_exl) epc_n = exc_pc;
        ebase_n = m_ebase;
        if (mtc_en && mtc_addr == 5'd15) ebase_n = mtc_data & 32'hFFFF_FFE0;
        if (t_exc) trap_q.push_back(m_ebase);
        else if (t_int) trap_q.push_back(VECTORED ? m_ebase + 32'(32 * (k_sel + 1)) : m_ebase);
        @(posedge clk_cpu);
        #1;
        if (live) begin
            m_ie = ie_n; m_exl = exl_n; m_im = im_n; m_ip = ip_n; m_exc = exc_n;
            m_epc = epc_n; m_ebase = ebase_n; m_trap = t_exc || t_int;
            m_prev = irq_s; m_prev_ok = 1;
        end
        exc_valid = 0; eret = 0; mtc_en = 0;
    endtask

    task automatic mtc(input logic [4:0] a, input logic [31:0] d);
        mtc_en = 1; mtc_addr = a; mtc_data = d;
        tick();
    endtask

    task automatic read_check(input logic [4:0] a, input logic [31:0] exp, input string name);
        mfc_addr = a;
        #1;
        check(name, mfc_data, exp);
        tick();
    endtask

    // Monitor: compares the DUT against queued expectations, independent of the driver.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk_cpu);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                check("status_data", status_data, s.status);
                check("cause_data", cause_data, s.cause);
                check("epc_data", epc_data, s.epc);
                check("mfc_data", mfc_data, s.mfc);
                check("in_handler", 32'(in_handler), 32'(s.in_h));
                check("trap_valid", 32'(trap_valid), 32'(s.trap));
                if (s.eret_chk) check("eret_pc", eret_pc, s.eret_pc);
            end
            if (trap_valid) begin
                if (trap_q.size() == 0) check("trap_unexpected", 32'(trap_valid), 32'd0);
                else check("trap_vector", trap_vector, trap_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected run to end");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk_cpu);
        #1;
        tick(); tick();
        rst = 0;

        // Reset values through the read port.
        read_check(5'd12, 32'h0, "rst_status");
        read_check(5'd13, 32'h0, "rst_cause");
        read_check(5'd14, 32'h0, "rst_epc");
        read_check(5'd15, 32'h80, "rst_ebase");
        check("rst_trap_valid", 32'(trap_valid), 32'd0);

        // Single interrupt on line 1.
        mtc(5'd12, 32'h0000_0301);
        irq_i = 4'b0010; int_pc = 32'h400;
        tick();
        check("ip1_set", 32'(cause_data[9]), 32'd1);
        tick();
        check("irq1_trap_valid", 32'(trap_valid), 32'd1);
        check("irq1_vector", trap_vector, EXP_VEC_IRQ1);
        check("irq1_epc", epc_data, 32'h400);
        check("irq1_exl", 32'(in_handler), 32'd1);
        tick();
        check("irq1_pulse_end", 32'(trap_valid), 32'd0);

        // W1C of IP1, then a clear racing a rising edge.
        mtc(5'd13, 32'h0000_0200);
        check("ip1_w1c", 32'(cause_data[9]), 32'd0);
        eret = 1;
        tick();
        check("eret_exit", 32'(in_handler), 32'd0);
        mtc(5'd12, 32'h0000_0300);
        irq_i = 4'b0000;
        tick();
        irq_i = 4'b0010;
        mtc(5'd13, 32'h0000_0200);
        check("ip1_rise_wins", 32'(cause_data[9]), 32'd1);
        mtc(5'd13, 32'h0000_0200);
        check("ip1_level_no_reset", 32'(cause_data[9]), 32'd0);
        irq_i = 4'b0000;
        tick();

        // Two simultaneous requests: lowest index first, the other after eret.
        mtc(5'd12, 32'h0000_0501);
        irq_i = 4'b0101;
        tick();
        tick();
        check("irq0_vector", trap_vector, EXP_VEC_IRQ0);
        check("irq0_exccode", 32'(cause_data[6:2]), 32'd0);
        check("irq2_pending", 32'(cause_data[10]), 32'd1);
        mtc(5'd13, 32'h0000_0100);
        eret = 1;
        #1;
        check("eret_pc", eret_pc, 32'h400);
        tick();
        check("eret_to_run", 32'(in_handler), 32'd0);
        tick();
        check("irq2_trap_valid", 32'(trap_valid), 32'd1);
        check("irq2_vector", trap_vector, EXP_VEC_IRQ2);
        check("irq2_exl", 32'(in_handler), 32'd1);

        // Nested exception keeps EPC; exception beats eret.
        exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h800;
        tick();
        check("nest_exccode", 32'(cause_data[6:2]), 32'd12);
        check("nest_epc", epc_data, 32'h400);
        check("nest_trap_valid", 32'(trap_valid), 32'd1);
        check("nest_vector", trap_vector, 32'h80);
        exc_valid = 1; exc_code = 5'd1; eret = 1;
        tick();
        check("exc_eret_exl", 32'(in_handler), 32'd1);
        check("exc_eret_code", 32'(cause_data[6:2]), 32'd1);
        mtc(5'd13, 32'h0000_0400);
        eret = 1;
        tick();
        irq_i = 4'b0000;
        mtc(5'd12, 32'h0);

        // Reset during a trap pulse, with a request held high across release.
        mtc(5'd12, 32'h0000_0101);
        irq_i = 4'b0001;
        tick();
        tick();
        rst = 1;
        #1;
        check("rst_kills_pulse", 32'(trap_valid), 32'd0);
        tick(); tick();
        rst = 0;
        tick(); tick();
        check("no_ip_after_rst", cause_data, 32'h0);
        irq_i = 4'b0000;
        tick();
        irq_i = 4'b0001;
        tick();
        check("ip0_after_refall", 32'(cause_data[8]), 32'd1);
        irq_i = 4'b0000;
        mtc(5'd13, 32'h0000_0F00);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                rst = 1;
                tick(); tick();
                rst = 0;
            end
            if ($urandom_range(0, 9) == 0) irq_i = irq_i ^ N'(1 << $urandom_range(0, N - 1));
            exc_valid = ($urandom_range(0, 29) == 0);
            exc_code = 5'($urandom);
            exc_pc = $urandom;
            int_pc = $urandom;
            eret = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                mtc_en = 1;
                mtc_addr = 5'($urandom_range(11, 16));
                mtc_data = $urandom;
                if (mtc_addr == 5'd12 && $urandom_range(0, 3) != 0) mtc_data[1] = 1'b0;
            end
            mfc_addr = 5'($urandom_range(10, 17));
            tick();
        end

        tick(); tick();
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        check("trap_q_drained", 32'(trap_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
